ldpc_dec_ctrl: RTL and testbench

Top-level sequencer for the LDPC decoder datapath (vertex-to-check LLR store and its check/variable node units). It accepts a frame start, streams channel LLRs into the 36 cell memories with a valid/ready handshake, then alternates check-node and variable-node phases until parity passes or the iteration limit is hit. It also runs an output phase. It drives the 4-bit phase code, sync strobe and latched code rate consumed by the LLR store and node units.

---
 rtl/ldpc_dec_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ldpc_dec_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_dec_ctrl.sv
// LDPC decoder top-level sequencer.
// Accepts a frame start, streams channel LLRs into the cell memories, then
// alternates check-node and variable-node phases until parity passes or the
// iteration limit is reached, runs the hard-decision output phase and
// reports completion. The phase code, sync strobe and latched code rate
// drive the LLR store and the node units.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; frame results (iter_cnt, early_stop) held
//   LOAD  | accepting FRM_LEN channel LLRs over the valid/ready handshake
//   CNU   | check-node phase, CNU_LEN cycles
//   VNU   | variable-node phase, VNU_LEN cycles; iteration decision on last
//   OUT   | hard-decision output phase, OUT_LEN cycles
//   DONE  | single-cycle completion pulse, then back to IDLE
module ldpc_dec_ctrl #(
    parameter int D_WID   = 6,
    parameter int N_CELL  = 36,
    parameter int Z       = 64,
    parameter int CNU_LEN = 64,
    parameter int VNU_LEN = 64,
    parameter int OUT_LEN = 64,
    parameter int IT_WID  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              code_rate_i,
    input  logic [IT_WID-1:0] max_iter,
    input  logic [D_WID-1:0]  llr_in,
    input  logic              llr_vld,
    output logic              llr_rdy,
    output logic [D_WID-1:0]  data_out,
    output logic              sync_out,
    output logic [3:0]        fsm_state,
    output logic              code_rate,
    input  logic              parity_ok,
    output logic [IT_WID-1:0] iter_cnt,
    output logic              busy,
    output logic              done,
    output logic              early_stop
);

    localparam int FRM_LEN = N_CELL * Z;
    localparam int PH_MAX0 = (CNU_LEN > VNU_LEN) ? CNU_LEN : VNU_LEN;
    localparam int PH_MAX  = (PH_MAX0 > OUT_LEN) ? PH_MAX0 : OUT_LEN;
    localparam int PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int LD_W    = (FRM_LEN > 1) ? $clog2(FRM_LEN) : 1;

    localparam logic [LD_W-1:0]   LD_LAST  = LD_W'(FRM_LEN - 1);
    localparam logic [PH_W-1:0]   CNU_LAST = PH_W'(CNU_LEN - 1);
    localparam logic [PH_W-1:0]   VNU_LAST = PH_W'(VNU_LEN - 1);
    localparam logic [PH_W-1:0]   OUT_LAST = PH_W'(OUT_LEN - 1);
    localparam logic [IT_WID-1:0] IT_ONE   = IT_WID'(1);
    localparam logic [IT_WID-1:0] IT_MAX   = {IT_WID{1'b1}};

    typedef enum logic [3:0] {
        S_IDLE = 4'h0,
        S_LOAD = 4'h1,
        S_CNU  = 4'h2,
        S_VNU  = 4'h3,
        S_OUT  = 4'h4,
        S_DONE = 4'h5
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [LD_W-1:0]   ld_cnt;
    logic [PH_W-1:0]   ph_cnt;
    logic [IT_WID-1:0] max_iter_q;
    logic [IT_WID-1:0] iter_inc;
    logic              xfer;
    logic              start_acc;
    logic              vnu_last;

    // Handshake and decision qualifiers shared by the next-state and context logic
    always_comb begin
        xfer      = (state_q == S_LOAD) && llr_vld;
        start_acc = (state_q == S_IDLE) && start;
        vnu_last  = (state_q == S_VNU) && (ph_cnt == VNU_LAST);
        iter_inc  = (iter_cnt == IT_MAX) ? iter_cnt : iter_cnt + IT_ONE;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the iteration decision uses the post-increment count
    // and parity wins when it coincides with the iteration limit
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (xfer && (ld_cnt == LD_LAST)) state_d = S_CNU;
            end
            S_CNU: begin
                if (ph_cnt == CNU_LAST) state_d = S_VNU;
            end
            S_VNU: begin
                if (ph_cnt == VNU_LAST) begin
                    if (parity_ok || (iter_inc == max_iter_q)) state_d = S_OUT;
                    else                                       state_d = S_CNU;
                end
            end
            S_OUT: begin
                if (ph_cnt == OUT_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        llr_rdy   = (state_q == S_LOAD);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        fsm_state = state_q;
    end

    // Load and phase counters, cleared on every state change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_cnt <= '0;
            ph_cnt <= '0;
        end else if (state_d != state_q) begin
            ld_cnt <= '0;
            ph_cnt <= '0;
        end else begin
            if (xfer) ld_cnt <= ld_cnt + 1'b1;
            if ((state_q == S_CNU) || (state_q == S_VNU) || (state_q == S_OUT))
                ph_cnt <= ph_cnt + 1'b1;
        end
    end

    // Load path: one-cycle registered LLR with aligned sync strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
            sync_out <= 1'b0;
        end else begin
            sync_out <= xfer;
            if (xfer) data_out <= llr_in;
        end
    end

    // Frame context: latched on accepted start, iteration results held until the next one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_rate  <= 1'b0;
            max_iter_q <= '0;
            iter_cnt   <= '0;
            early_stop <= 1'b0;
        end else if (start_acc) begin
            code_rate  <= code_rate_i;
            max_iter_q <= (max_iter == '0) ? IT_ONE : max_iter;
            iter_cnt   <= '0;
            early_stop <= 1'b0;
        end else if (vnu_last) begin
            iter_cnt <= iter_inc;
            if (parity_ok) early_stop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ldpc_dec_ctrl.sv
// Self-checking bench for ldpc_dec_ctrl. Each frame's expected per-cycle
// phase trace is built up front from the frame rules (load length from the
// valid pattern, iteration count from the limit and parity plan), then
// compared cycle by cycle against the DUT.
module tb_ldpc_dec_ctrl;

    localparam int FRM = 2304;
    localparam int PH  = 64;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       code_rate_i = 1'b0;
    logic [4:0] max_iter = '0;
    logic [5:0] llr_in = '0;
    logic       llr_vld = 1'b0;
    logic       llr_rdy;
    logic [5:0] data_out;
    logic       sync_out;
    logic [3:0] fsm_state;
    logic       code_rate;
    logic       parity_ok = 1'b0;
    logic [4:0] iter_cnt;
    logic       busy;
    logic       done;
    logic       early_stop;

    int checks = 0;
    int failures = 0;
    logic [5:0] exp_data = '0;

    ldpc_dec_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .code_rate_i(code_rate_i),
        .max_iter   (max_iter),
        .llr_in     (llr_in),
        .llr_vld    (llr_vld),
        .llr_rdy    (llr_rdy),
        .data_out   (data_out),
        .sync_out   (sync_out),
        .fsm_state  (fsm_state),
        .code_rate  (code_rate),
        .parity_ok  (parity_ok),
        .iter_cnt   (iter_cnt),
        .busy       (busy),
        .done       (done),
        .early_stop (early_stop)
    );

    always #5 clk = ~clk;

    // One frame: vld_mode 0 = continuous, 1 = toggling 1,0, 2 = random 3/4 density.
    // stop_it = iteration whose last VNU cycle sees parity_ok=1 (0 = never).
    task automatic run_frame(input string name, input bit rate, input int maxit,
                             input int vld_mode, input int stop_it);
        bit         vq[$];
        logic [3:0] st_q[$];
        int sent = 0, n_it = 0, eff, iters = 0, bad = 0, syncs = 0, dones = 0;
        bit es = 1'b0, prev_xfer = 1'b0, exp_es, last_vnu, xfer_now;
        string first_msg = "";
        logic [3:0] s;

        while (sent < FRM) begin
            bit v;
            case (vld_mode)
                0: v = 1'b1;
                1: v = (vq.size() % 2 == 0);
                default: v = ($urandom % 4) != 0;
            endcase
            vq.push_back(v);
            if (v) sent++;
        end
        eff = (maxit == 0) ? 1 : maxit;
        for (int i = 1; i <= 31; i++) begin
            n_it = i;
            if (i == stop_it) begin es = 1'b1; break; end
            if (i == eff) break;
        end
        for (int i = 0; i < vq.size(); i++) st_q.push_back(4'h1);
        for (int i = 0; i < n_it; i++) begin
            for (int j = 0; j < PH; j++) st_q.push_back(4'h2);
            for (int j = 0; j < PH; j++) st_q.push_back(4'h3);
        end
        for (int j = 0; j < PH; j++) st_q.push_back(4'h4);
        st_q.push_back(4'h5);
        for (int j = 0; j < 4; j++) st_q.push_back(4'h0);

        @(posedge clk); #1;
        start = 1'b1; code_rate_i = rate; max_iter = 5'(maxit);
        llr_vld = 1'($urandom); llr_in = 6'($urandom); parity_ok = 1'($urandom);
        @(posedge clk);
        for (int k = 0; k < st_q.size(); k++) begin
            s = st_q[k];
            #1;
            start       = (s == 4'h0 || s == 4'h5) ? 1'b0 : (($urandom % 8) == 0);
            if (s == 4'h5) start = 1'($urandom);
            code_rate_i = 1'($urandom);
            max_iter    = 5'($urandom);
            llr_vld     = (k < vq.size()) ? vq[k] : 1'($urandom);
            llr_in      = 6'($urandom);
            last_vnu    = (s == 4'h3) && ((k + 1 >= st_q.size()) || st_q[k+1] != 4'h3);
            parity_ok   = last_vnu ? (iters + 1 == stop_it) : 1'($urandom);
            @(negedge clk);
            exp_es = (s == 4'h4 || s == 4'h5 || s == 4'h0) ? es : 1'b0;
            if (sync_out) syncs++;
            if (done) dones++;
            if (fsm_state !== s || llr_rdy !== (s == 4'h1) || busy !== (s != 4'h0) ||
                done !== (s == 4'h5) || sync_out !== prev_xfer || data_out !== exp_data ||
                iter_cnt !== 5'(iters) || early_stop !== exp_es || code_rate !== rate) begin
                if (bad == 0)
                    first_msg = $sformatf("cycle %0d state=%0d/%0d rdy=%b sync=%b/%b data=%0d/%0d iter=%0d/%0d es=%b/%b rate=%b/%b",
                        k, fsm_state, s, llr_rdy, sync_out, prev_xfer, data_out, exp_data,
                        iter_cnt, iters, early_stop, exp_es, code_rate, rate);
                bad++;
            end
            xfer_now = (k < vq.size()) && vq[k];
            if (xfer_now) exp_data = llr_in;
            prev_xfer = xfer_now;
            if (last_vnu) iters++;
            @(posedge clk);
        end
        #1;
        start = 1'b0; llr_vld = 1'b0; parity_ok = 1'b0;

        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL %s trace: %0d bad cycles, got/want at first: %s", name, bad, first_msg);
        end
        checks++;
        if (syncs !== FRM) begin
            failures++;
            $display("FAIL %s sync_count: got %0d want %0d", name, syncs, FRM);
        end
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL %s done_count: got %0d want 1", name, dones);
        end
        checks++;
        if (iter_cnt !== 5'(n_it)) begin
            failures++;
            $display("FAIL %s final_iter_cnt: got %0d want %0d", name, iter_cnt, n_it);
        end
        checks++;
        if (early_stop !== es) begin
            failures++;
            $display("FAIL %s final_early_stop: got %b want %b", name, early_stop, es);
        end
        checks++;
        if (code_rate !== rate) begin
            failures++;
            $display("FAIL %s final_code_rate: got %b want %b", name, code_rate, rate);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if (fsm_state !== 4'h0 || llr_rdy !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            sync_out !== 1'b0 || data_out !== 6'h0 || iter_cnt !== 5'h0 ||
            code_rate !== 1'b0 || early_stop !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: state=%0d rdy=%b busy=%b done=%b sync=%b data=%0d iter=%0d rate=%b es=%b want all 0",
                fsm_state, llr_rdy, busy, done, sync_out, data_out, iter_cnt, code_rate, early_stop);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_data = '0;
    endtask

    task automatic test_continuous_load();
        run_frame("continuous_limit3", 1'b1, 3, 0, 0);
    endtask

    task automatic test_stalled_load();
        run_frame("stalled_load", 1'b0, 1, 1, 0);
    endtask

    task automatic test_early_stop();
        run_frame("early_stop_it2", 1'b1, 10, 0, 2);
        run_frame("coincide_limit2", 1'b0, 2, 0, 2);
    endtask

    task automatic test_edge_inputs();
        run_frame("max_iter_zero", 1'b1, 0, 0, 0);
        run_frame("max_iter_31", 1'b0, 31, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++)
            run_frame($sformatf("random_%0d", f), 1'($urandom), $urandom_range(0, 5), 2,
                      $urandom_range(0, 6));
    endtask

    task automatic test_reset_midload();
        int dones = 0, bad = 0;
        @(posedge clk); #1;
        start = 1'b1; code_rate_i = 1'b1; max_iter = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            llr_vld = 1'b1; llr_in = 6'($urandom);
            @(posedge clk); #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (fsm_state !== 4'h0 || llr_rdy !== 1'b0 || busy !== 1'b0 || sync_out !== 1'b0 ||
            data_out !== 6'h0 || code_rate !== 1'b0 || iter_cnt !== 5'h0) begin
            failures++;
            $display("FAIL midload_reset: state=%0d rdy=%b busy=%b sync=%b data=%0d rate=%b iter=%0d want all 0",
                fsm_state, llr_rdy, busy, sync_out, data_out, code_rate, iter_cnt);
        end
        exp_data = '0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            llr_vld = 1'($urandom); llr_in = 6'($urandom); parity_ok = 1'($urandom);
            @(negedge clk);
            if (done) dones++;
            if (fsm_state !== 4'h0 || sync_out !== 1'b0) bad++;
        end
        checks++;
        if (dones !== 0 || bad !== 0) begin
            failures++;
            $display("FAIL post_reset_idle: done pulses=%0d non-idle cycles=%0d want 0 and 0", dones, bad);
        end
    endtask

    initial begin
        test_reset();
        test_continuous_load();
        test_stalled_load();
        test_early_stop();
        test_edge_inputs();
        test_back_to_back();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
